eth_phy_10g_tx_ipg: RTL and testbench

Transmit-side inter-packet-gap side channel for the 10GBASE-R PHY. Accepts a byte-stream message (up to 63 bytes), buffers it, and substitutes its payload, in 6-byte chunks, into idle control blocks of the encoded 64b/66b stream. It sits between the TX 64b/66b encoder and the scrambler. It is the transmit counterpart of the RX path's `rx_len`/`rx_ipg_data` extraction.

---
 rtl/eth_ipg_pkg.sv | 21 ++
 rtl/eth_phy_10g_tx_ipg_msg_buf.sv | 51 +++++
 rtl/eth_phy_10g_tx_ipg.sv | 124 ++++++++++++
 tb/tb_eth_phy_10g_tx_ipg.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_ipg_pkg.sv
// Shared constants and types for the 10GBASE-R transmit inter-packet-gap side channel.
package eth_ipg_pkg;

  localparam logic [1:0]  SYNC_DATA       = 2'b10;
  localparam logic [1:0]  SYNC_CTRL       = 2'b01;
  localparam logic [7:0]  BLOCK_TYPE_CTRL = 8'h1E;
  localparam logic [63:0] IDLE_BLOCK      = 64'h1E;
  localparam int          IPG_CHUNK_BYTES = 6;
  localparam int          MSG_DEPTH       = 63;

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } ipg_state_e;

  // Bytes carried by the next chunk: min(rem, 6).
  function automatic logic [2:0] chunk_len(input logic [5:0] rem);
    return (rem > 6'(IPG_CHUNK_BYTES)) ? 3'(IPG_CHUNK_BYTES) : rem[2:0];
  endfunction

endpackage

// File: rtl/eth_phy_10g_tx_ipg_msg_buf.sv
// Message byte store: 63x8 registers, write counter, read pointer and a 6-byte zero-padded chunk port.
module eth_ipg_msg_buf
  import eth_ipg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wr_en,
  input  logic [7:0]  i_wr_data,
  input  logic        i_wr_clr,
  input  logic        i_rd_clr,
  input  logic        i_rd_adv,
  input  logic [2:0]  i_rd_n,
  output logic [5:0]  o_wr_cnt,
  output logic [47:0] o_chunk
);

  logic [7:0] r_mem [MSG_DEPTH];
  logic [5:0] r_wr_cnt;
  logic [5:0] r_rd_ptr;
  logic [6:0] w_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_wr_clr)     r_wr_cnt <= '0;
      else if (i_wr_en) r_wr_cnt <= r_wr_cnt + 6'd1;
      if (i_rd_clr)      r_rd_ptr <= '0;
      else if (i_rd_adv) r_rd_ptr <= r_rd_ptr + {3'b000, i_rd_n};
    end
  end

  // Contents need no reset: a message is only read after it has been written.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_wr_cnt] <= i_wr_data;
  end

  always_comb begin
    o_chunk = '0;
    w_idx   = '0;
    for (int k = 0; k < IPG_CHUNK_BYTES; k++) begin
      w_idx = {1'b0, r_rd_ptr} + 7'(k);
      if ((3'(k) < i_rd_n) && (w_idx < 7'(MSG_DEPTH)))
        o_chunk[8*k +: 8] = r_mem[w_idx[5:0]];
    end
  end

  assign o_wr_cnt = r_wr_cnt;

endmodule

// File: rtl/eth_phy_10g_tx_ipg.sv
// Buffers a side-channel message and substitutes it, 6 bytes at a time, into exact-match idle blocks.
// Optional macro IPG_HOLDOFF_EN: only an idle whose predecessor was also an idle may carry a chunk.
module eth_phy_10g_tx_ipg
  import eth_ipg_pkg::*;
#(
  parameter int         DATA_WIDTH     = 64,
  parameter int         HDR_WIDTH      = 2,
  parameter int         MAX_MSG_BYTES  = 63,
  parameter logic [7:0] IPG_BLOCK_TYPE = 8'h1E
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] encoded_tx_data,
  input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
  input  logic [7:0]            tx_ipg_data,
  input  logic                  tx_ipg_valid,
  input  logic                  tx_ipg_last,
  output logic                  tx_ipg_ready,
  output logic [DATA_WIDTH-1:0] serdes_tx_data,
  output logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
  output logic                  ipg_sent,
  output logic                  ipg_trunc,
  output ipg_state_e            o_dbg_state
);

  // Byte handshake: a byte moves when tx_ipg_valid && tx_ipg_ready at a rising edge;
  // ready is registered and is only ever high in FILL.

  ipg_state_e            r_state;
  logic [5:0]            r_rem;
  logic                  r_ready;
  logic                  r_sent;
  logic                  r_trunc;
  logic                  r_prev_idle;
  logic [DATA_WIDTH-1:0] r_data;
  logic [HDR_WIDTH-1:0]  r_hdr;

  logic        w_idle;
  logic        w_elig;
  logic        w_accept;
  logic        w_commit;
  logic        w_sub;
  logic        w_done;
  logic [2:0]  w_n;
  logic [5:0]  w_wr_cnt;
  logic [47:0] w_chunk;

  assign w_idle = (encoded_tx_hdr == SYNC_CTRL) && (encoded_tx_data == IDLE_BLOCK);
`ifdef IPG_HOLDOFF_EN
  assign w_elig = w_idle && r_prev_idle;
`else
  assign w_elig = w_idle;
`endif

  assign w_accept = tx_ipg_valid && r_ready && (r_state == FILL);
  assign w_commit = w_accept && (tx_ipg_last || (w_wr_cnt == 6'(MAX_MSG_BYTES - 1)));
  assign w_sub    = (r_state == SEND) && w_elig;
  assign w_n      = chunk_len(r_rem);
  assign w_done   = w_sub && (r_rem <= 6'(IPG_CHUNK_BYTES));

  eth_ipg_msg_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_accept),
    .i_wr_data (tx_ipg_data),
    .i_wr_clr  (w_done),
    .i_rd_clr  (w_commit),
    .i_rd_adv  (w_sub),
    .i_rd_n    (w_n),
    .o_wr_cnt  (w_wr_cnt),
    .o_chunk   (w_chunk)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_rem       <= '0;
      r_ready     <= 1'b0;
      r_sent      <= 1'b0;
      r_trunc     <= 1'b0;
      r_prev_idle <= 1'b0;
      r_data      <= IDLE_BLOCK;
      r_hdr       <= SYNC_CTRL;
    end else begin
      r_prev_idle <= w_idle;
      r_sent      <= 1'b0;
      r_trunc     <= 1'b0;
      r_data      <= encoded_tx_data;
      r_hdr       <= encoded_tx_hdr;
      case (r_state)
        FILL: begin
          r_ready <= 1'b1;
          if (w_commit) begin
            r_rem   <= w_wr_cnt + 6'd1;
            r_state <= SEND;
            r_ready <= 1'b0;
            r_trunc <= ~tx_ipg_last;
          end
        end
        SEND: begin
          // ready stays low through the ipg_sent cycle and returns one cycle later.
          r_ready <= 1'b0;
          if (w_sub) begin
            r_data <= {w_chunk, 2'b00, r_rem, IPG_BLOCK_TYPE};
            r_rem  <= r_rem - {3'b000, w_n};
            if (w_done) begin
              r_sent  <= 1'b1;
              r_state <= FILL;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign tx_ipg_ready   = r_ready;
  assign serdes_tx_data = r_data;
  assign serdes_tx_hdr  = r_hdr;
  assign ipg_sent       = r_sent;
  assign ipg_trunc      = r_trunc;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_eth_phy_10g_tx_ipg.sv
// Scoreboard bench for eth_phy_10g_tx_ipg: message-level reference model, randomized blocks and bytes.
module tb_eth_phy_10g_tx_ipg;
  import eth_ipg_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [63:0] encoded_tx_data;
  logic [1:0]  encoded_tx_hdr;
  logic [7:0]  tx_ipg_data;
  logic        tx_ipg_valid;
  logic        tx_ipg_last;
  logic        tx_ipg_ready;
  logic [63:0] serdes_tx_data;
  logic [1:0]  serdes_tx_hdr;
  logic        ipg_sent;
  logic        ipg_trunc;
  ipg_state_e  dbg_state;

  eth_phy_10g_tx_ipg dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .encoded_tx_data (encoded_tx_data),
    .encoded_tx_hdr  (encoded_tx_hdr),
    .tx_ipg_data     (tx_ipg_data),
    .tx_ipg_valid    (tx_ipg_valid),
    .tx_ipg_last     (tx_ipg_last),
    .tx_ipg_ready    (tx_ipg_ready),
    .serdes_tx_data  (serdes_tx_data),
    .serdes_tx_hdr   (serdes_tx_hdr),
    .ipg_sent        (ipg_sent),
    .ipg_trunc       (ipg_trunc),
    .o_dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  hdr;
    logic        sent;
    logic        trunc;
    logic        ready;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Message-level view: bytes being collected, bytes still to be sent, what ready should show now.
  logic [7:0] m_coll[$];
  logic [7:0] m_send[$];
  logic [7:0] msg_q[$];
  bit         m_sending;
  bit         m_ready;
  bit         m_prev_idle;

  task automatic model_reset();
    m_coll.delete();
    m_send.delete();
    m_sending   = 1'b0;
    m_ready     = 1'b0;
    m_prev_idle = 1'b0;
  endtask

  task automatic model_step(input logic [63:0] blk, input logic [1:0] hdr, input logic v,
                            input logic [7:0] d, input logic last);
    exp_t e;
    bit   idle;
    bit   elig;
    int   n;
    idle = (hdr == 2'b01) && (blk == 64'h1E);
`ifdef IPG_HOLDOFF_EN
    elig = idle && m_prev_idle;
`else
    elig = idle;
`endif
    e      = '0;
    e.data = blk;
    e.hdr  = hdr;
    if (m_sending) begin
      if (elig) begin
        n = (m_send.size() > 6) ? 6 : m_send.size();
        e.data       = 64'h1E;
        e.data[15:8] = 8'(m_send.size());
        for (int k = 0; k < n; k++) e.data[16 + 8*k +: 8] = m_send.pop_front();
        if (m_send.size() == 0) begin
          m_sending = 1'b0;
          e.sent    = 1'b1;
        end
      end
      e.ready = 1'b0;
    end else begin
      if (m_ready && v) begin
        m_coll.push_back(d);
        if (last || m_coll.size() == 63) begin
          e.trunc   = !last;
          m_send    = m_coll;
          m_coll.delete();
          m_sending = 1'b1;
        end
      end
      e.ready = !m_sending;
    end
    m_ready     = e.ready;
    m_prev_idle = idle;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("data",  serdes_tx_data,     mon_e.data);
      check("hdr",   64'(serdes_tx_hdr), 64'(mon_e.hdr));
      check("sent",  64'(ipg_sent),      64'(mon_e.sent));
      check("trunc", 64'(ipg_trunc),     64'(mon_e.trunc));
      check("ready", 64'(tx_ipg_ready),  64'(mon_e.ready));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [63:0] blk, input logic [1:0] hdr, input logic v,
                       input logic [7:0] d, input logic last);
    @(negedge clk);
    rst_n           = 1'b1;
    encoded_tx_data = blk;
    encoded_tx_hdr  = hdr;
    tx_ipg_valid    = v;
    tx_ipg_data     = d;
    tx_ipg_last     = last;
    model_step(blk, hdr, v, d, last);
  endtask

  task automatic idle_cycle();
    cycle(64'h1E, 2'b01, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic rst_cycle();
    exp_t e;
    @(negedge clk);
    rst_n           = 1'b0;
    encoded_tx_data = 64'h1E;
    encoded_tx_hdr  = 2'b01;
    tx_ipg_valid    = 1'b0;
    tx_ipg_data     = 8'h00;
    tx_ipg_last     = 1'b0;
    model_reset();
    e      = '0;
    e.data = 64'h1E;
    e.hdr  = 2'b01;
    exp_q.push_back(e);
  endtask

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  task automatic gen_block(output logic [63:0] b, output logic [1:0] h);
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) begin
      b = 64'h1E; h = 2'b01;
    end else if (r == 6) begin
      b = {$urandom(), $urandom()}; h = 2'b10;
    end else if (r == 7) begin
      b = {$urandom(), $urandom()}; b[7:0] = 8'h1E;
      if (b[63:8] == 56'h0) b[8] = 1'b1;
      h = 2'b01;
    end else if (r == 8) begin
      b = {$urandom(), $urandom()}; b[7:0] = 8'h87; h = 2'b01;
    end else begin
      b = 64'h1E; h = 2'b10;
    end
  endtask

  task automatic send_bytes(input bit rand_blk, input int gap_pct);
    int          i;
    int          guard;
    logic        v;
    logic        acc;
    logic [63:0] b;
    logic [1:0]  h;
    i = 0;
    guard = 0;
    while (i < msg_q.size() && guard < 3000) begin
      v = ($urandom_range(0, 99) >= gap_pct);
      if (rand_blk) gen_block(b, h);
      else begin b = 64'h1E; h = 2'b01; end
      acc = m_ready && v;
      cycle(b, h, v, msg_q[i], (i == msg_q.size() - 1));
      if (acc) i++;
      guard++;
    end
    check("send_bytes_done", 64'(i), 64'(msg_q.size()));
  endtask

  task automatic drain(input bit rand_blk);
    int          g;
    logic [63:0] b;
    logic [1:0]  h;
    g = 0;
    while (m_sending && g < 600) begin
      if (rand_blk) gen_block(b, h);
      else begin b = 64'h1E; h = 2'b01; end
      cycle(b, h, 1'b0, 8'h00, 1'b0);
      g++;
    end
    check("drain_done", 64'(m_sending), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  int cnt;
  int sent_seen;
  bit found;

  initial begin
    rst_n           = 1'b0;
    encoded_tx_data = 64'h1E;
    encoded_tx_hdr  = 2'b01;
    tx_ipg_data     = 8'h00;
    tx_ipg_valid    = 1'b0;
    tx_ipg_last     = 1'b0;
    model_reset();

    repeat (3) rst_cycle();
    idle_cycle();
    sample();
    check("ready_after_reset", 64'(tx_ipg_ready), 64'd1);
    check("state_after_reset", 64'(dbg_state), 64'(FILL));

    // three-byte message
    msg_q = '{8'hAA, 8'hBB, 8'hCC};
    send_bytes(1'b0, 0);
    idle_cycle();
    sample();
    check("msg3_block", serdes_tx_data, 64'h0000_00CC_BBAA_031E);
    check("msg3_sent", 64'(ipg_sent), 64'd1);
    idle_cycle();
    sample();
    check("msg3_ready_again", 64'(tx_ipg_ready), 64'd1);

    // ten-byte message with a data block between idles
    msg_q.delete();
    for (int k = 1; k <= 10; k++) msg_q.push_back(8'(k));
    send_bytes(1'b0, 0);
    idle_cycle();
    sample();
    check("msg10_chunk1", serdes_tx_data, 64'h0605_0403_0201_0A1E);
    cycle(64'hDEAD_BEEF_0123_4567, 2'b10, 1'b0, 8'h00, 1'b0);
    sample();
    check("msg10_data_pass", serdes_tx_data, 64'hDEAD_BEEF_0123_4567);
    check("msg10_data_hdr", 64'(serdes_tx_hdr), 64'd2);
`ifdef IPG_HOLDOFF_EN
    idle_cycle();
    sample();
    check("msg10_holdoff_idle", serdes_tx_data, 64'h1E);
`endif
    idle_cycle();
    sample();
    check("msg10_chunk2", serdes_tx_data, 64'h0000_0A09_0807_041E);
    check("msg10_sent", 64'(ipg_sent), 64'd1);
    drain(1'b0);
    idle_cycle();

    // overflow: 64 bytes offered, no last
    for (int k = 0; k < 64; k++) cycle(64'h1E, 2'b01, 1'b1, 8'(k + 1), 1'b0);
    cnt = 1;
    found = 1'b0;
    for (int j = 0; j < 20 && !found; j++) begin
      idle_cycle();
      cnt++;
      sample();
      if (ipg_sent) found = 1'b1;
    end
    check("ovf_idles_used", 64'(cnt), 64'd11);
    drain(1'b0);
    idle_cycle();

    // terminate block followed by an idle while a message is pending
    msg_q = '{8'h5A, 8'hA5};
    send_bytes(1'b0, 0);
    cycle(64'h87, 2'b01, 1'b0, 8'h00, 1'b0);
    idle_cycle();
    sample();
`ifdef IPG_HOLDOFF_EN
    check("holdoff_idle", serdes_tx_data, 64'h1E);
`else
    check("holdoff_idle", serdes_tx_data, 64'h0000_0000_A55A_021E);
`endif
    drain(1'b0);
    idle_cycle();

    // reset in the middle of SEND
    msg_q.delete();
    for (int k = 0; k < 10; k++) msg_q.push_back(8'($urandom_range(0, 255)));
    send_bytes(1'b0, 0);
    idle_cycle();
    rst_cycle();
    rst_cycle();
    sent_seen = 0;
    for (int j = 0; j < 12; j++) begin
      idle_cycle();
      sample();
      if (ipg_sent) sent_seen++;
    end
    check("rst_send_no_sent", 64'(sent_seen), 64'd0);
    check("rst_send_ready", 64'(tx_ipg_ready), 64'd1);

    // randomized messages and block mix
    for (int m = 0; m < 25; m++) begin
      msg_q.delete();
      for (int k = 0; k < $urandom_range(1, 70); k++) msg_q.push_back(8'($urandom_range(0, 255)));
      send_bytes(1'b1, 30);
      drain(1'b1);
    end

    repeat (3) idle_cycle();
    sample();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
